// File: rtl/gt_rx_reset_pkg.sv
// Shared definitions for the GT RX reset sequencer: one-hot lane state encoding,
// retry counter width and counter-sizing helpers.
package gt_rx_reset_pkg;

  typedef enum logic [3:0] {
    ST_RESET     = 4'b0001,
    ST_WAIT_LOCK = 4'b0010,
    ST_VERIFY    = 4'b0100,
    ST_UP        = 4'b1000
  } lane_state_e;

  localparam int RETRY_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter only ever reaches max_cycles-1 before being cleared.
  function automatic int cnt_w_for(input int max_cycles);
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/gt_rx_reset_lane.sv
// One RX lane reset FSM with its phase counter; optional saturating retry counter
// when RX_RESET_SEQ_RETRY_CNT_EN is defined.
module gt_rx_reset_lane
  import gt_rx_reset_pkg::*;
#(
  parameter int RST_HOLD_CYCLES  = 32,
  parameter int LOCK_WAIT_CYCLES = 67108864,
  parameter int STABLE_CYCLES    = 1024,
  parameter int CNT_W            = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               good,
  input  logic               enable,
  output logic               rx_reset,
  output logic               lane_up
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
  ,
  output logic [RETRY_W-1:0] retry_cnt
`endif
);

  localparam int MAX_CYCLES = max3(RST_HOLD_CYCLES, LOCK_WAIT_CYCLES, STABLE_CYCLES);

  if (CNT_W < cnt_w_for(MAX_CYCLES)) begin : g_cnt_w_err
    $error("CNT_W=%0d cannot hold %0d cycles", CNT_W, MAX_CYCLES);
  end

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rx_reset_q, rx_reset_d;
  logic             lane_up_q, lane_up_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (!enable) begin
      state_d = ST_RESET;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (good) begin
            state_d = ST_VERIFY;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end
        end
        ST_VERIFY: begin
          if (!good) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_UP;
            cnt_d   = '0;
          end
        end
        ST_UP: begin
          cnt_d = '0;
          if (!good) state_d = ST_RESET;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs are registered from the next state so they change with the state.
    rx_reset_d = (state_d == ST_RESET);
    lane_up_d  = (state_d == ST_UP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      rx_reset_q <= 1'b1;
      lane_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_reset_q <= rx_reset_d;
      lane_up_q  <= lane_up_d;
    end
  end

  assign rx_reset = rx_reset_q;
  assign lane_up  = lane_up_q;

`ifdef RX_RESET_SEQ_RETRY_CNT_EN
  logic               retry_evt;
  logic [RETRY_W-1:0] retry_q, retry_d;

  // A retry is any fault-driven return to RESET; masking a lane is not a retry.
  always_comb begin
    retry_evt = enable && !good &&
                ((state_q == ST_UP) || (state_q == ST_VERIFY) ||
                 ((state_q == ST_WAIT_LOCK) && (cnt_q == LOCK_LAST)));
    retry_d   = retry_q;
    if (retry_evt && (retry_q != '1)) retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end

  assign retry_cnt = retry_q;
`endif

endmodule

// File: rtl/gt_rx_reset_seq.sv
// Multi-lane GT RX reset sequencer: per-lane FSMs plus registered channel_up.
// Define RX_RESET_SEQ_RETRY_CNT_EN to expose per-lane retry_cnt.
module gt_rx_reset_seq
  import gt_rx_reset_pkg::*;
#(
  parameter int NUM_LANES        = 4,
  parameter int RST_HOLD_CYCLES  = 32,
  parameter int LOCK_WAIT_CYCLES = 67108864,
  parameter int STABLE_CYCLES    = 1024,
  parameter int CNT_W            = 27
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LANES-1:0]         rx_status,
  input  logic [NUM_LANES-1:0]         rx_aligned,
  input  logic [NUM_LANES-1:0]         lane_mask,
  output logic [NUM_LANES-1:0]         gtwiz_rx_reset,
  output logic [NUM_LANES-1:0]         lane_up,
  output logic                         channel_up
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
  ,
  output logic [RETRY_W*NUM_LANES-1:0] retry_cnt
`endif
);

  logic channel_up_q, channel_up_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gt_rx_reset_lane #(
      .RST_HOLD_CYCLES (RST_HOLD_CYCLES),
      .LOCK_WAIT_CYCLES(LOCK_WAIT_CYCLES),
      .STABLE_CYCLES   (STABLE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .good     (rx_status[i] & rx_aligned[i]),
      .enable   (lane_mask[i]),
      .rx_reset (gtwiz_rx_reset[i]),
      .lane_up  (lane_up[i])
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
      ,
      .retry_cnt(retry_cnt[RETRY_W*i +: RETRY_W])
`endif
    );
  end

  // Disabled lanes count as up, but an all-disabled channel is never up.
  always_comb begin
    channel_up_d = (&(lane_up | ~lane_mask)) & (|lane_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) channel_up_q <= 1'b0;
    else       channel_up_q <= channel_up_d;
  end

  assign channel_up = channel_up_q;

endmodule

// File: tb/tb_gt_rx_reset_seq.sv
// Bench for gt_rx_reset_seq (2 lanes, short timings): countdown-based lane model
// checked every cycle, plus hand-computed directed expectations.
module tb_gt_rx_reset_seq;

  localparam int NL        = 2;
  localparam int RST_HOLD  = 4;
  localparam int LOCK_WAIT = 16;
  localparam int STABLE    = 8;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_VER  = 2;
  localparam int PH_UP   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] rx_status, rx_aligned, lane_mask;
  logic [NL-1:0] gtwiz_rx_reset, lane_up;
  logic          channel_up;
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
  logic [8*NL-1:0] retry_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  gt_rx_reset_seq #(
    .NUM_LANES       (NL),
    .RST_HOLD_CYCLES (RST_HOLD),
    .LOCK_WAIT_CYCLES(LOCK_WAIT),
    .STABLE_CYCLES   (STABLE),
    .CNT_W           (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_status     (rx_status),
    .rx_aligned    (rx_aligned),
    .lane_mask     (lane_mask),
    .gtwiz_rx_reset(gtwiz_rx_reset),
    .lane_up       (lane_up),
    .channel_up    (channel_up)
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    ,
    .retry_cnt     (retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each phase holds a countdown of cycles left; entering a phase reloads it.
  int  m_ph   [NL];
  int  m_left [NL];
  bit  m_ch;
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
  int  m_retry[NL];
`endif
  int  nph, nleft;
  bit  g, fail, all_ok;

  always @(posedge clk) begin
    all_ok = 1'b1;
    for (int i = 0; i < NL; i++)
      if (m_ph[i] != PH_UP && lane_mask[i]) all_ok = 1'b0;
    m_ch <= !reset && all_ok && (lane_mask != '0);
    for (int i = 0; i < NL; i++) begin
      g     = rx_status[i] && rx_aligned[i];
      nph   = m_ph[i];
      nleft = m_left[i];
      fail  = 1'b0;
      if (reset || !lane_mask[i]) begin
        nph   = PH_RST;
        nleft = RST_HOLD;
      end else if (m_ph[i] == PH_RST) begin
        nleft--;
        if (nleft == 0) begin nph = PH_WAIT; nleft = LOCK_WAIT; end
      end else if (m_ph[i] == PH_WAIT) begin
        if (g) begin
          nph = PH_VER; nleft = STABLE;
        end else begin
          nleft--;
          if (nleft == 0) begin nph = PH_RST; nleft = RST_HOLD; fail = 1'b1; end
        end
      end else if (m_ph[i] == PH_VER) begin
        if (!g) begin
          nph = PH_RST; nleft = RST_HOLD; fail = 1'b1;
        end else begin
          nleft--;
          if (nleft == 0) nph = PH_UP;
        end
      end else begin
        if (!g) begin nph = PH_RST; nleft = RST_HOLD; fail = 1'b1; end
      end
      m_ph[i]   <= nph;
      m_left[i] <= nleft;
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
      if (reset)                        m_retry[i] <= 0;
      else if (fail && m_retry[i] < 255) m_retry[i] <= m_retry[i] + 1;
`endif
    end
  end

  logic [NL-1:0] e_rx, e_up;

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NL; i++) begin
        e_rx[i] = (m_ph[i] == PH_RST);
        e_up[i] = (m_ph[i] == PH_UP);
      end
      chk("model gtwiz_rx_reset", gtwiz_rx_reset, e_rx);
      chk("model lane_up", lane_up, e_up);
      chk("model channel_up", channel_up, m_ch);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
      for (int i = 0; i < NL; i++)
        chk("model retry_cnt", retry_cnt[8*i +: 8], m_retry[i][7:0]);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where reset is released.
  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    rx_status  = 2'b11;
    rx_aligned = 2'b11;
    lane_mask  = 2'b11;
    tick(1);
    check_en = 1'b1;

    // 1: reset values, pulse length, lock timing
    chk("reset rx_reset", gtwiz_rx_reset, 2'b11);
    chk("reset lane_up", lane_up, 2'b00);
    chk("reset channel_up", channel_up, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("t1 rx_reset held", gtwiz_rx_reset, 2'b11);
    tick(1);
    chk("t1 rx_reset released", gtwiz_rx_reset, 2'b00);
    tick(8);
    chk("t1 lane_up not yet", lane_up, 2'b00);
    tick(1);
    chk("t1 lane_up", lane_up, 2'b11);
    chk("t1 channel_up lags", channel_up, 1'b0);
    tick(1);
    chk("t1 channel_up", channel_up, 1'b1);

    // 2: lane 0 never locks -> timeout every 20 cycles
    rx_status = 2'b10;
    do_reset();
    tick(19);
    chk("t2 rx_reset0 low", gtwiz_rx_reset[0], 1'b0);
    tick(1);
    chk("t2 rx_reset0 re-pulse", gtwiz_rx_reset[0], 1'b1);
    chk("t2 lane1 up", lane_up[1], 1'b1);
    chk("t2 channel down", channel_up, 1'b0);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t2 retry0 =1", retry_cnt[7:0], 8'd1);
    tick(20);
    chk("t2 retry0 =2", retry_cnt[7:0], 8'd2);
    tick(20);
    chk("t2 retry0 =3", retry_cnt[7:0], 8'd3);
    chk("t2 retry1 =0", retry_cnt[15:8], 8'd0);
`else
    tick(40);
`endif

    // 3: one-cycle alignment loss on lane 1 while UP
    rx_status = 2'b11;
    do_reset();
    tick(14);
    chk("t3 channel up", channel_up, 1'b1);
    rx_aligned = 2'b01;
    tick(1);
    rx_aligned = 2'b11;
    chk("t3 lane_up drop", lane_up, 2'b01);
    chk("t3 rx_reset1 rise", gtwiz_rx_reset, 2'b10);
    tick(1);
    chk("t3 channel drop", channel_up, 1'b0);
    tick(11);
    chk("t3 relock pending", lane_up[1], 1'b0);
    tick(1);
    chk("t3 relocked", lane_up[1], 1'b1);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t3 retry1", retry_cnt[15:8], 8'd1);
`endif

    // 4: glitch on lane 0 at VERIFY cnt=5
    do_reset();
    tick(10);
    rx_status = 2'b10;
    tick(1);
    rx_status = 2'b11;
    chk("t4 back to reset", gtwiz_rx_reset, 2'b01);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t4 retry0", retry_cnt[7:0], 8'd1);
`endif
    tick(2);
    chk("t4 lane0 not up", lane_up, 2'b10);
    tick(10);
    chk("t4 lane0 still not up", lane_up[0], 1'b0);
    tick(1);
    chk("t4 lane0 up", lane_up[0], 1'b1);

    // 5: masking
    lane_mask = 2'b01;
    do_reset();
    tick(14);
    chk("t5 lane_up mask01", lane_up, 2'b01);
    chk("t5 lane1 held", gtwiz_rx_reset, 2'b10);
    chk("t5 channel lane0 only", channel_up, 1'b1);
    lane_mask = 2'b00;
    tick(1);
    chk("t5 channel mask00", channel_up, 1'b0);
    chk("t5 all held", gtwiz_rx_reset, 2'b11);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t5 no retry on mask", retry_cnt, 16'd0);
`endif
    lane_mask = 2'b11;
    tick(16);

    // 6: retry saturation, then reset mid-sequence
    rx_status = 2'b10;
    do_reset();
    tick(5080);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t6 retry0 =254", retry_cnt[7:0], 8'd254);
`endif
    tick(20);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t6 retry0 =255", retry_cnt[7:0], 8'd255);
`endif
    tick(900);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t6 retry0 saturated", retry_cnt[7:0], 8'd255);
`endif
    tick(4);
    rx_status = 2'b11;
    tick(3);
    chk("t6 lane1 up, lane0 verifying", lane_up, 2'b10);
    reset = 1'b1;
    tick(1);
    chk("t6 reset rx_reset", gtwiz_rx_reset, 2'b11);
    chk("t6 reset lane_up", lane_up, 2'b00);
    chk("t6 reset channel_up", channel_up, 1'b0);
`ifdef RX_RESET_SEQ_RETRY_CNT_EN
    chk("t6 reset retry", retry_cnt, 16'd0);
`endif
    reset = 1'b0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
